// File: rtl/pvci2ahb_master.sv
// pvci2ahb_master: 8-bit PVCI target port bridged onto a single-beat AHB master.
// Each PVCI request becomes one byte-sized SINGLE NONSEQ transfer.
// RETRY/SPLIT responses re-issue the same transfer, up to MAX_RETRY issues in total.
// The optional hready stall timeout is compiled in when PVCI2AHB_TIMEOUT_EN is defined.
module pvci2ahb_master #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned MAX_RETRY   = 4,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        pvci_valid,
    input  logic        pvci_rd,
    input  logic [7:0]  pvci_addr,
    input  logic [7:0]  pvci_wd,
    output logic        pvci_ack,
    output logic [7:0]  pvci_rdata,
    output logic        pvci_err,
    output logic        hbusreq,
    input  logic        hgrant,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic [1:0]  hresp
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_ADDR = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam int unsigned RW = $clog2(MAX_RETRY + 1);

    // Zero retries or a zero-cycle timeout would make the bridge unusable.
    if (MAX_RETRY == 0 || TIMEOUT_CYC == 0) begin : g_param_check
        $error("pvci2ahb_master: MAX_RETRY and TIMEOUT_CYC must be non-zero");
    end

    logic [2:0]    state;
    logic          rd_q;
    logic [7:0]    wd_q;
    logic [RW-1:0] retry_cnt;
    logic [RW-1:0] retry_nxt;
    logic          tmo_hit;

    assign retry_nxt = retry_cnt + RW'(1);

`ifdef PVCI2AHB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tmo_cnt;
    logic          stall;

    assign stall   = ((state == ST_ADDR) || (state == ST_DATA)) && !hready;
    assign tmo_hit = stall && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    // Count consecutive hready-low cycles of the address/data phases.
    always_ff @(posedge hclk) begin
        if (hreset || !stall) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Transfer sequencing, request latching and response capture.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state      <= ST_IDLE;
            rd_q       <= 1'b0;
            wd_q       <= '0;
            haddr      <= '0;
            retry_cnt  <= '0;
            pvci_err   <= 1'b0;
            pvci_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pvci_valid) begin
                        rd_q      <= pvci_rd;
                        wd_q      <= pvci_wd;
                        haddr     <= BASE_ADDR + {24'b0, pvci_addr};
                        retry_cnt <= '0;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (hgrant && hready) begin
                        state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (tmo_hit) begin
                        pvci_err <= 1'b1;
                        state    <= ST_RESP;
                    end else if (hready) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tmo_hit) begin
                        pvci_err <= 1'b1;
                        state    <= ST_RESP;
                    end else if (hready) begin
                        case (hresp)
                            HRESP_OKAY: begin
                                pvci_err <= 1'b0;
                                if (rd_q) begin
                                    pvci_rdata <= hrdata[{haddr[1:0], 3'b000} +: 8];
                                end
                                state <= ST_RESP;
                            end
                            HRESP_ERROR: begin
                                pvci_err <= 1'b1;
                                state    <= ST_RESP;
                            end
                            default: begin
                                // RETRY and SPLIT: re-arbitrate and re-issue the same beat.
                                retry_cnt <= retry_nxt;
                                if (retry_nxt < RW'(MAX_RETRY)) begin
                                    state <= ST_REQ;
                                end else begin
                                    pvci_err <= 1'b1;
                                    state    <= ST_RESP;
                                end
                            end
                        endcase
                    end
                end
                ST_RESP: begin
                    retry_cnt <= '0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Bus-side and PVCI-side outputs decoded from the current phase.
    always_comb begin
        pvci_ack = (state == ST_RESP);
        hbusreq  = (state == ST_REQ) || (state == ST_ADDR);
        htrans   = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
        hwrite   = (state == ST_ADDR) && !rd_q;
        hwdata   = (state == ST_DATA) ? {4{wd_q}} : '0;
        hsize    = 3'b000;
        hburst   = 3'b000;
    end

endmodule

// File: tb/tb_pvci2ahb_master.sv
// Self-checking bench for pvci2ahb_master: table-driven single transfers plus
// hand-written grant-delay, wait-state, ERROR, RETRY, reset and timeout sequences.
module tb_pvci2ahb_master;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [1:0]  OKAY = 2'b00;
    localparam logic [1:0]  ERR  = 2'b01;
    localparam logic [1:0]  RTY  = 2'b10;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        pvci_valid;
    logic        pvci_rd;
    logic [7:0]  pvci_addr;
    logic [7:0]  pvci_wd;
    logic        pvci_ack;
    logic [7:0]  pvci_rdata;
    logic        pvci_err;
    logic        hbusreq;
    logic        hgrant;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic [1:0]  hresp;

    always #5 hclk = ~hclk;

    pvci2ahb_master #(
        .BASE_ADDR  (BASE),
        .MAX_RETRY  (4),
        .TIMEOUT_CYC(8)
    ) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .pvci_valid(pvci_valid),
        .pvci_rd   (pvci_rd),
        .pvci_addr (pvci_addr),
        .pvci_wd   (pvci_wd),
        .pvci_ack  (pvci_ack),
        .pvci_rdata(pvci_rdata),
        .pvci_err  (pvci_err),
        .hbusreq   (hbusreq),
        .hgrant    (hgrant),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hburst    (hburst),
        .hwdata    (hwdata),
        .hrdata    (hrdata),
        .hready    (hready),
        .hresp     (hresp)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Per-cycle bus-side script, indexed by cycle number from request start.
    bit         sg[64];
    bit         sr[64];
    logic [1:0] sp[64];

    // Observations of the last transfer.
    int          r_ack_cyc;
    logic        r_err;
    logic [7:0]  r_rdata;
    int          r_ns;
    logic [31:0] r_haddr;
    logic        r_hwrite;
    logic [31:0] r_hwdata;
    logic        r_busreq1;
    logic        r_busreq_d;

    typedef struct {
        logic        rd;
        logic [7:0]  addr;
        logic [7:0]  wd;
        logic [31:0] rdata_bus;
        logic [1:0]  resp;
        logic [31:0] e_haddr;
        logic [31:0] e_hwdata;
        logic        e_hwrite;
        logic [7:0]  e_rdata;
        logic        e_err;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic script_default();
        for (int i = 0; i < 64; i++) begin
            sg[i] = 1'b1;
            sr[i] = 1'b1;
            sp[i] = OKAY;
        end
    endtask

    task automatic apply(input int c);
        hgrant = sg[c];
        hready = sr[c];
        hresp  = sp[c];
    endtask

    // Issue one PVCI request, play the script, observe until ack or budget.
    task automatic run_xfer(input logic rd, input logic [7:0] addr, input logic [7:0] wd);
        int cyc;
        bit done;
        bit prev_ns;
        bit got_ns;
        bit got_wd;
        r_ack_cyc  = -1;
        r_err      = 1'bx;
        r_rdata    = 'x;
        r_ns       = 0;
        r_haddr    = '0;
        r_hwrite   = 1'b0;
        r_hwdata   = '0;
        r_busreq1  = 1'b0;
        r_busreq_d = 1'b1;
        @(posedge hclk);
        #1;
        pvci_valid = 1'b1;
        pvci_rd    = rd;
        pvci_addr  = addr;
        pvci_wd    = wd;
        apply(0);
        cyc     = 0;
        done    = 0;
        prev_ns = 0;
        got_ns  = 0;
        got_wd  = 0;
        while (!done && cyc < 60) begin
            @(negedge hclk);
            if (prev_ns && !got_wd) begin
                r_hwdata   = hwdata;
                r_busreq_d = hbusreq;
                got_wd     = 1;
            end
            prev_ns = (htrans == 2'b10) && hready;
            if (htrans == 2'b10) begin
                r_ns++;
                if (!got_ns) begin
                    r_haddr  = haddr;
                    r_hwrite = hwrite;
                    got_ns   = 1;
                end
            end
            if (cyc == 1) r_busreq1 = hbusreq;
            if (pvci_ack) begin
                done      = 1;
                r_ack_cyc = cyc;
                r_err     = pvci_err;
                r_rdata   = pvci_rdata;
            end
            @(posedge hclk);
            #1;
            cyc++;
            apply(cyc);
        end
        pvci_valid = 1'b0;
        hgrant     = 1'b1;
        hready     = 1'b1;
        hresp      = OKAY;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{1'b0, 8'h10, 8'hA5, 32'h0000_0000, OKAY, 32'h4000_0010, 32'hA5A5_A5A5, 1'b1, 8'h00, 1'b0};
        tbl[1] = '{1'b1, 8'h13, 8'h00, 32'h1122_3344, OKAY, 32'h4000_0013, 32'h0000_0000, 1'b0, 8'h11, 1'b0};
        tbl[2] = '{1'b1, 8'h12, 8'h00, 32'h1122_3344, OKAY, 32'h4000_0012, 32'h0000_0000, 1'b0, 8'h22, 1'b0};
        tbl[3] = '{1'b0, 8'h01, 8'h3C, 32'h1122_3344, OKAY, 32'h4000_0001, 32'h3C3C_3C3C, 1'b1, 8'h22, 1'b0};
        tbl[4] = '{1'b1, 8'h00, 8'h00, 32'hDEAD_BEEF, OKAY, 32'h4000_0000, 32'h0000_0000, 1'b0, 8'hEF, 1'b0};
        tbl[5] = '{1'b1, 8'h01, 8'h00, 32'hDEAD_BEEF, OKAY, 32'h4000_0001, 32'h0000_0000, 1'b0, 8'hBE, 1'b0};
        tbl[6] = '{1'b0, 8'hFF, 8'h5A, 32'h0000_0000, ERR,  32'h4000_00FF, 32'h5A5A_5A5A, 1'b1, 8'hBE, 1'b1};
        tbl[7] = '{1'b1, 8'h02, 8'h00, 32'hCAFE_F00D, ERR,  32'h4000_0002, 32'h0000_0000, 1'b0, 8'hBE, 1'b1};

        hreset     = 1'b1;
        pvci_valid = 1'b0;
        pvci_rd    = 1'b0;
        pvci_addr  = '0;
        pvci_wd    = '0;
        hgrant     = 1'b1;
        hready     = 1'b1;
        hresp      = OKAY;
        hrdata     = '0;
        repeat (3) @(posedge hclk);
        #1;
        hreset = 1'b0;

        @(negedge hclk);
        chk("reset ack",     {31'b0, pvci_ack}, 32'd0);
        chk("reset err",     {31'b0, pvci_err}, 32'd0);
        chk("reset rdata",   {24'b0, pvci_rdata}, 32'd0);
        chk("reset hbusreq", {31'b0, hbusreq}, 32'd0);
        chk("reset htrans",  {30'b0, htrans}, 32'd0);
        chk("reset haddr",   haddr, 32'd0);
        chk("reset hwrite",  {31'b0, hwrite}, 32'd0);
        chk("reset hwdata",  hwdata, 32'd0);
        chk("hsize",         {29'b0, hsize}, 32'd0);
        chk("hburst",        {29'b0, hburst}, 32'd0);

        // Zero-wait single transfers with a static response.
        for (int i = 0; i < 8; i++) begin
            script_default();
            for (int c = 0; c < 64; c++) sp[c] = tbl[i].resp;
            hrdata = tbl[i].rdata_bus;
            run_xfer(tbl[i].rd, tbl[i].addr, tbl[i].wd);
            chk($sformatf("v%0d ack_cycle", i), r_ack_cyc, 32'd4);
            chk($sformatf("v%0d err", i),       {31'b0, r_err}, {31'b0, tbl[i].e_err});
            chk($sformatf("v%0d rdata", i),     {24'b0, r_rdata}, {24'b0, tbl[i].e_rdata});
            chk($sformatf("v%0d haddr", i),     r_haddr, tbl[i].e_haddr);
            chk($sformatf("v%0d hwrite", i),    {31'b0, r_hwrite}, {31'b0, tbl[i].e_hwrite});
            chk($sformatf("v%0d hwdata", i),    r_hwdata, tbl[i].e_hwdata);
            chk($sformatf("v%0d nonseq", i),    r_ns, 32'd1);
            chk($sformatf("v%0d busreq_req", i),  {31'b0, r_busreq1}, 32'd1);
            chk($sformatf("v%0d busreq_data", i), {31'b0, r_busreq_d}, 32'd0);
        end

        // Grant held off 5 cycles, 3 data-phase wait states: ack at 4+8.
        script_default();
        for (int c = 0; c <= 5; c++) sg[c] = 1'b0;
        for (int c = 8; c <= 10; c++) sr[c] = 1'b0;
        run_xfer(1'b0, 8'h20, 8'h77);
        chk("delay ack_cycle", r_ack_cyc, 32'd12);
        chk("delay nonseq",    r_ns, 32'd1);
        chk("delay err",       {31'b0, r_err}, 32'd0);
        chk("delay hwdata",    r_hwdata, 32'h7777_7777);

        // RETRY on every attempt: four issues then failed.
        script_default();
        for (int c = 0; c < 64; c++) sp[c] = RTY;
        run_xfer(1'b1, 8'h04, 8'h00);
        chk("retry_all ack_cycle", r_ack_cyc, 32'd13);
        chk("retry_all nonseq",    r_ns, 32'd4);
        chk("retry_all err",       {31'b0, r_err}, 32'd1);
        chk("retry_all rdata",     {24'b0, r_rdata}, 32'h0000_00BE);

        // RETRY once, then OKAY on the re-issue.
        script_default();
        sp[3] = RTY;
        hrdata = 32'h9988_7766;
        run_xfer(1'b1, 8'h03, 8'h00);
        chk("retry_once ack_cycle", r_ack_cyc, 32'd7);
        chk("retry_once nonseq",    r_ns, 32'd2);
        chk("retry_once err",       {31'b0, r_err}, 32'd0);
        chk("retry_once rdata",     {24'b0, r_rdata}, 32'h0000_0099);

        // Two-cycle ERROR: first cycle has hready low and must be ignored.
        script_default();
        sp[3] = ERR;
        sr[3] = 1'b0;
        sp[4] = ERR;
        run_xfer(1'b0, 8'h08, 8'hC3);
        chk("error2 ack_cycle", r_ack_cyc, 32'd5);
        chk("error2 nonseq",    r_ns, 32'd1);
        chk("error2 err",       {31'b0, r_err}, 32'd1);
        chk("error2 rdata",     {24'b0, r_rdata}, 32'h0000_0099);

        // Reset asserted while in the data phase: abandoned, no ack.
        script_default();
        @(posedge hclk);
        #1;
        pvci_valid = 1'b1;
        pvci_rd    = 1'b0;
        pvci_addr  = 8'h44;
        pvci_wd    = 8'h11;
        repeat (3) @(posedge hclk);
        #1;
        pvci_valid = 1'b0;
        hreset     = 1'b1;
        @(negedge hclk);
        chk("rst_mid in_data hwdata", hwdata, 32'h1111_1111);
        @(posedge hclk);
        #1;
        hreset = 1'b0;
        @(negedge hclk);
        chk("rst_mid ack",     {31'b0, pvci_ack}, 32'd0);
        chk("rst_mid err",     {31'b0, pvci_err}, 32'd0);
        chk("rst_mid rdata",   {24'b0, pvci_rdata}, 32'd0);
        chk("rst_mid hbusreq", {31'b0, hbusreq}, 32'd0);
        chk("rst_mid htrans",  {30'b0, htrans}, 32'd0);
        chk("rst_mid haddr",   haddr, 32'd0);
        chk("rst_mid hwrite",  {31'b0, hwrite}, 32'd0);
        chk("rst_mid hwdata",  hwdata, 32'd0);
        begin
            int acks;
            acks = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge hclk);
                if (pvci_ack) acks++;
            end
            chk("rst_mid no_late_ack", acks, 32'd0);
        end

`ifdef PVCI2AHB_TIMEOUT_EN
        // hready stuck low from the address phase: timeout after 8 stalls.
        script_default();
        for (int c = 2; c < 64; c++) sr[c] = 1'b0;
        run_xfer(1'b0, 8'h30, 8'h12);
        chk("timeout ack_cycle", r_ack_cyc, 32'd10);
        chk("timeout err",       {31'b0, r_err}, 32'd1);
        chk("timeout nonseq",    r_ns, 32'd8);
        @(negedge hclk);
        chk("timeout htrans_after", {30'b0, htrans}, 32'd0);
        chk("timeout busreq_after", {31'b0, hbusreq}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
